audio_dac_serializer: RTL and testbench
=======================================

Name: audio_dac_serializer

Overview:
- Transmit-side counterpart of the codec ADC capture path: takes stereo PCM frames from the processor/DSP side and serializes them onto DACDAT.
- Codec is bus master: BCLK and DACLRCK are inputs, asynchronous to clk, and are oversampled in the clk domain.
- Sits between the Avalon-facing sample producer and the codec pins. Format is left-justified, MSB first, DACLRCK high = left channel.
- Includes a small frame FIFO to absorb producer jitter.

Parameters:
- DATA_WIDTH, 24, bits per channel word (16..32).
- FIFO_DEPTH, 8, stereo frames buffered; power of two, >=2.
- CNT_WIDTH, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock; must be >= 8x BCLK (50 MHz nominal).
- reset  in  1  synchronous, active-high.
- enable  in  1  output enable; sampled at left-frame start only.
- sample_left  in  DATA_WIDTH  left PCM word, two's complement.
- sample_right  in  DATA_WIDTH  right PCM word.
- sample_valid  in  1  producer offers a frame.
- sample_ready  out  1  block accepts a frame this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- bclk  in  1  codec bit clock, async.
- daclrck  in  1  codec DAC word clock, async.
- dacdat  out  1  serial data to codec, registered.
- underrun_count  out  CNT_WIDTH  frames replaced by silence; saturating.

Behaviour:
- Reset values: dacdat=0, sample_ready=0 during reset and 1 on the first cycle after, fifo_level=0, underrun_count=0, FSM=WAIT_FRAME, FIFO empty.
- Synchronizers: bclk and daclrck each pass through 2 flops, plus 1 history flop for edge detection.
  - Events: lr_rise, lr_fall, bclk_fall.
  - Pin edge to dacdat change latency is exactly 3 clk cycles.
- FIFO handshake:
  - Push when sample_valid && sample_ready.
  - sample_ready = !full, registered from the current level.
  - A pop in the same cycle does not raise ready for that cycle.
  - Simultaneous push and pop: level unchanged.
- FSM states: WAIT_FRAME, SHIFT, PAD.
- WAIT_FRAME:
  - dacdat=0. Leave only on lr_rise; the first lr_fall after reset is ignored.
  - On lr_rise: if enable && !empty, pop a frame and hold the right word in a register. Otherwise load zeros, and increment underrun_count if enable && empty.
  - Then load the left word, drive its MSB, bit counter=DATA_WIDTH-1, go to SHIFT.
- SHIFT:
  - Each bclk_fall: shift left, drive next bit, decrement counter.
  - When counter reaches 0 on bclk_fall, go to PAD with dacdat=0.
- PAD: dacdat=0 until the next LRCK edge.
- Frame start (lr_rise) in SHIFT or PAD: abort the current word and perform the WAIT_FRAME lr_rise action (pop or silence).
- lr_fall in SHIFT or PAD: load the held right word (zero if the frame was silence), drive its MSB, go to SHIFT.
- Short word slot (LRCK toggles before DATA_WIDTH bits): truncate; LSBs are dropped.
- Long slot: pad with 0.
- enable low at lr_rise: frame is silent, no pop, no underrun count. enable changes mid-frame have no effect until the next lr_rise.
- bclk_fall on the same cycle as an lr edge: the lr edge wins; the MSB of the new word is driven and no shift occurs.
- Reset mid-frame: immediate return to reset values; the current frame is lost; the next output begins at the next lr_rise.
- underrun_count saturates at all-ones; cleared only by reset.

Decomposition:
- Shared package audio_pkg holds:
  - typedef sample_t (logic [DATA_WIDTH-1:0]);
  - enum state_t {WAIT_FRAME, SHIFT, PAD};
  - constant SYNC_STAGES=2.
- One sub-module: audio_frame_fifo, a synchronous FIFO of {left,right}. It provides push/pop/full/empty/level, with show-ahead read data.
- The synchronizer, edge detect and FSM stay in the top-level block.

Test Plan:
- Single frame, DATA_WIDTH=24:
  - Stimulus: push L=0x800001, R=0x7FFFFE with BCLK=clk/16 and 64 BCLK per LRCK period.
  - Required: dacdat shows 1000...0001 after lr_rise, 0111...1110 after lr_fall, and 0 for the remaining 8 bits of each slot. underrun_count=0.
- Latency and edge priority:
  - Measure clk cycles from daclrck pin rise to dacdat MSB: exactly 3.
  - Force a bclk fall coincident with a daclrck edge: the new word's MSB is held, not shifted.
- FIFO full/backpressure:
  - Hold sample_valid=1 with no LRCK activity.
  - Required: exactly 8 frames accepted, sample_ready=0 afterwards, fifo_level=8.
  - After one lr_rise: level=7, and ready reasserts the following cycle.
- Underrun:
  - Stimulus: empty FIFO, enable=1, 3 frames of LRCK.
  - Required: dacdat all 0, underrun_count=3.
  - With enable=0 for 3 more frames: count stays 3 and no pops occur.
- Short and long slots:
  - 16 BCLK per channel: only the top 16 bits are sent.
  - 40 BCLK per channel: 24 data bits then 16 zeros.
  - FIFO pops exactly once per frame in both cases.
- Reset mid-word:
  - Stimulus: assert reset for 1 cycle during the 10th left bit.
  - Required: dacdat=0, level=0, count=0. A frame pushed afterwards appears starting at the next lr_rise, not at the next lr_fall.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC serializer slice.
package audio_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;

    // Flops between an async codec pin and its first use in the clk domain.
    localparam int SYNC_STAGES = 2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        SHIFT,
        PAD
    } state_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous stereo-frame FIFO with show-ahead read data and a registered
// ready flag that mirrors "not full" for the level held in the register.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             ready,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_next;

    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Qualify the requests and work out the next occupancy.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        do_push    = push && ready;
        do_pop     = pop && !empty;
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + LVL_ONE;
        end else if (!do_push && do_pop) begin
            level_next = level - LVL_ONE;
        end
    end

    // Pointers, level and the registered ready flag.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_next;
            ready <= (level_next != LVL_FULL);
        end
    end

    // Frame storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo serializer: oversamples the codec's BCLK/DACLRCK,
// pops one buffered frame per left-channel start and shifts it out MSB first.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         sample_left,
    input  logic [DATA_WIDTH-1:0]         sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          bclk,
    input  logic                          daclrck,
    output logic                          dacdat,
    output logic [CNT_WIDTH-1:0]          underrun_count
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [CNT_WIDTH-1:0] UNDER_ONE = CNT_WIDTH'(1);

    // Codec pin synchronizers and edge history.
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   bclk_hist;
    logic                   lr_hist;
    logic                   lr_rise;
    logic                   lr_fall;
    logic                   bclk_fall;

    // FIFO interface.
    logic [2*DATA_WIDTH-1:0] fifo_rd;
    logic [DATA_WIDTH-1:0]   rd_left;
    logic [DATA_WIDTH-1:0]   rd_right;
    logic                    fifo_empty;
    logic                    pop;

    // Serializer state and its next-state values.
    state_t                state, state_n;
    logic [CW-1:0]         bit_cnt, cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [DATA_WIDTH-1:0] right_hold, right_n;
    logic                  dacdat_n;
    logic [CNT_WIDTH-1:0]  under_n;

    audio_frame_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (sample_valid),
        .pop     (pop),
        .wr_data ({sample_left, sample_right}),
        .rd_data (fifo_rd),
        .ready   (sample_ready),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign {rd_left, rd_right} = fifo_rd;

    // Oversample the async pins; these flops are left out of reset so that a
    // reset while DACLRCK is high cannot manufacture a false frame start.
    always_ff @(posedge clk) begin
        bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
        lr_sync   <= {lr_sync[SYNC_STAGES-2:0], daclrck};
        bclk_hist <= bclk_sync[SYNC_STAGES-1];
        lr_hist   <= lr_sync[SYNC_STAGES-1];
    end

    assign lr_rise   =  lr_sync[SYNC_STAGES-1]   & ~lr_hist;
    assign lr_fall   = ~lr_sync[SYNC_STAGES-1]   &  lr_hist;
    assign bclk_fall = ~bclk_sync[SYNC_STAGES-1] &  bclk_hist;

    // Next-state logic: LRCK edges outrank BCLK so a coincident fall keeps the new MSB.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt;
        shift_n  = shift_reg;
        right_n  = right_hold;
        dacdat_n = dacdat;
        under_n  = underrun_count;
        pop      = 1'b0;
        if (lr_rise) begin
            if (enable && !fifo_empty) begin
                pop     = 1'b1;
                shift_n = rd_left;
                right_n = rd_right;
            end else begin
                shift_n = '0;
                right_n = '0;
                if (enable && (underrun_count != '1)) begin
                    under_n = underrun_count + UNDER_ONE;
                end
            end
            dacdat_n = shift_n[DATA_WIDTH-1];
            cnt_n    = CNT_LAST;
            state_n  = SHIFT;
        end else if (lr_fall && (state != WAIT_FRAME)) begin
            shift_n  = right_hold;
            dacdat_n = right_hold[DATA_WIDTH-1];
            cnt_n    = CNT_LAST;
            state_n  = SHIFT;
        end else if (bclk_fall && (state == SHIFT)) begin
            if (bit_cnt == '0) begin
                dacdat_n = 1'b0;
                state_n  = PAD;
            end else begin
                shift_n  = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                dacdat_n = shift_reg[DATA_WIDTH-2];
                cnt_n    = bit_cnt - CNT_ONE;
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_FRAME;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            right_hold     <= '0;
            dacdat         <= 1'b0;
            underrun_count <= '0;
        end else begin
            state          <= state_n;
            bit_cnt        <= cnt_n;
            shift_reg      <= shift_n;
            right_hold     <= right_n;
            dacdat         <= dacdat_n;
            underrun_count <= under_n;
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed plus randomized bench for audio_dac_serializer; expected serial
// streams come from a queue-based frame model and a bit-slot formula.
module tb_audio_dac_serializer;
    import audio_pkg::*;

    localparam int DW        = 24;
    localparam int DEPTH     = 8;
    localparam int CW        = 16;
    localparam int HALF_BCLK = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    sample_t     sample_left = '0;
    sample_t     sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [3:0]  fifo_level;
    logic        bclk = 1'b1;
    logic        daclrck = 1'b0;
    logic        dacdat;
    logic [CW-1:0] underrun_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frames the DUT should hold, and the expected underrun count.
    sample_t q_left[$];
    sample_t q_right[$];
    int      exp_underruns = 0;

    audio_dac_serializer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .fifo_level     (fifo_level),
        .bclk           (bclk),
        .daclrck        (daclrck),
        .dacdat         (dacdat),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bits a codec would latch on BCLK rises in an nbits slot: the word MSB
    // first for its first min(keep, DW) bits, zeros afterwards.
    function automatic logic [63:0] exp_slot(input sample_t w, input int nbits, input int keep);
        logic [63:0] v = '0;
        for (int k = 0; k < nbits; k++) begin
            v = {v[62:0], (k < keep && k < DW) ? w[DW-1-k] : 1'b0};
        end
        return v;
    endfunction

    // Drive one channel slot as the codec master would: LRCK changes with the
    // first BCLK fall; dacdat is captured on every BCLK rise. Optionally pulses
    // reset during bit rst_bit and checks the reset values right after it.
    task automatic slot(input logic lr, input int nbits, input int rst_bit,
                        output logic [63:0] cap, output int first_one);
        cap = '0;
        first_one = 0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) daclrck = lr;
            for (int i = 1; i <= HALF_BCLK; i++) begin
                @(negedge clk);
                if (k == 0 && first_one == 0 && dacdat === 1'b1) first_one = i;
                if (k == rst_bit && i == 5) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check("midword reset dacdat", 64'(dacdat), 64'(0));
                    check("midword reset level", 64'(fifo_level), 64'(0));
                    check("midword reset underruns", 64'(underrun_count), 64'(0));
                    check("midword reset ready", 64'(sample_ready), 64'(0));
                end
            end
            bclk = 1'b1;
            cap = {cap[62:0], dacdat};
            wait_neg(HALF_BCLK - 1);
        end
    endtask

    // One full LRCK frame checked against the model's choice of frame or silence.
    task automatic run_frame(input int nbits, input string tag, output int lat);
        sample_t     l;
        sample_t     r;
        logic [63:0] cap;
        int          dummy;
        if (enable && q_left.size() > 0) begin
            l = q_left.pop_front();
            r = q_right.pop_front();
        end else begin
            l = '0;
            r = '0;
            if (enable && exp_underruns < 65535) exp_underruns++;
        end
        slot(1'b1, nbits, -1, cap, lat);
        check($sformatf("%s left/%0d", tag, nbits), cap, exp_slot(l, nbits, DW));
        slot(1'b0, nbits, -1, cap, dummy);
        check($sformatf("%s right/%0d", tag, nbits), cap, exp_slot(r, nbits, DW));
        check($sformatf("%s level", tag), 64'(fifo_level), 64'(q_left.size()));
        check($sformatf("%s underruns", tag), 64'(underrun_count), 64'(exp_underruns));
    endtask

    task automatic push_frame(input sample_t l, input sample_t r);
        int n = 0;
        @(negedge clk);
        while (sample_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("push ready timeout", 64'(sample_ready), 64'(1));
        end else begin
            sample_left  = l;
            sample_right = r;
            sample_valid = 1'b1;
            q_left.push_back(l);
            q_right.push_back(r);
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        int          accepted;
        int          nb;
        int          np;
        sample_t     l0;
        sample_t     r0;
        logic [63:0] cap;

        // Reset values.
        wait_neg(3);
        check("reset ready", 64'(sample_ready), 64'(0));
        check("reset dacdat", 64'(dacdat), 64'(0));
        check("reset level", 64'(fifo_level), 64'(0));
        check("reset underruns", 64'(underrun_count), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", 64'(sample_ready), 64'(1));
        enable = 1'b1;

        // Single known frame; MSB 1 after idle also gives the pin-to-dacdat latency.
        push_frame(24'h800001, 24'h7FFFFE);
        run_frame(32, "single", lat);
        check("lrck to dacdat latency", 64'(lat), 64'(3));

        // Backpressure: valid held with no LRCK activity.
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            l0 = sample_t'($urandom);
            l0[DW-1] = 1'b1;
            r0 = sample_t'($urandom);
            sample_left  = l0;
            sample_right = r0;
            sample_valid = 1'b1;
            if (sample_ready === 1'b1) begin
                accepted++;
                q_left.push_back(l0);
                q_right.push_back(r0);
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("frames accepted", 64'(accepted), 64'(DEPTH));
        check("ready when full", 64'(sample_ready), 64'(0));
        check("level when full", 64'(fifo_level), 64'(DEPTH));

        // One frame start: pop lands on the third clock, ready returns with it.
        l0 = q_left.pop_front();
        r0 = q_right.pop_front();
        bclk = 1'b0;
        daclrck = 1'b1;
        wait_neg(2);
        check("ready before pop", 64'(sample_ready), 64'(0));
        check("level before pop", 64'(fifo_level), 64'(DEPTH));
        @(negedge clk);
        check("level after pop", 64'(fifo_level), 64'(DEPTH - 1));
        check("ready after pop", 64'(sample_ready), 64'(1));
        check("msb after pop", 64'(dacdat), 64'(l0[DW-1]));
        wait_neg(5);
        bclk = 1'b1;
        wait_neg(HALF_BCLK);
        bclk = 1'b0;
        daclrck = 1'b0;
        wait_neg(HALF_BCLK);
        bclk = 1'b1;
        wait_neg(HALF_BCLK);

        // Drain in order, including short and long slots.
        run_frame(32, "drain", lat);
        run_frame(32, "drain", lat);
        run_frame(32, "drain", lat);
        run_frame(16, "short", lat);
        run_frame(16, "short", lat);
        run_frame(40, "long", lat);
        run_frame(40, "long", lat);

        // Underrun: empty FIFO, enabled, then disabled with a frame waiting.
        for (int i = 0; i < 3; i++) run_frame(32, "underrun", lat);
        check("underrun total", 64'(underrun_count), 64'(3));
        push_frame(sample_t'($urandom), sample_t'($urandom));
        enable = 1'b0;
        for (int i = 0; i < 3; i++) run_frame(32, "disabled", lat);
        check("disabled keeps frame", 64'(fifo_level), 64'(1));
        enable = 1'b1;
        run_frame(32, "reenabled", lat);

        // Reset during the 10th left bit.
        push_frame(sample_t'($urandom), sample_t'($urandom));
        push_frame(sample_t'($urandom), sample_t'($urandom));
        l0 = q_left.pop_front();
        r0 = q_right.pop_front();
        slot(1'b1, 32, 9, cap, lat);
        check("reset cuts left word", cap, exp_slot(l0, 32, 9));
        q_left.delete();
        q_right.delete();
        exp_underruns = 0;
        push_frame(sample_t'($urandom), sample_t'($urandom));
        slot(1'b0, 32, -1, cap, lat);
        check("no output at lr_fall after reset", cap, 64'(0));
        check("frame still queued", 64'(fifo_level), 64'(1));
        run_frame(32, "after reset", lat);

        // Randomized traffic: pushes, enable and slot length vary per frame.
        for (int f = 0; f < 10; f++) begin
            np = $urandom_range(0, 2);
            for (int j = 0; j < np; j++) begin
                if (q_left.size() < DEPTH) push_frame(sample_t'($urandom), sample_t'($urandom));
            end
            enable = ($urandom_range(0, 3) != 0);
            nb = 16 + 8 * $urandom_range(0, 3);
            run_frame(nb, "random", lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
